mux_arb_reg: RTL
================

// Module: mux_arb_reg
// PURPOSE
//  Parametrised N-to-1 datapath selector with a registered output and valid/ready handshake.
//  Two select modes: fixed (external sel) and round-robin arbitration among valid channels.
//  Sits between multiple producers (e.g. writeback sources, bus masters) and one consumer.
//  One pipeline register; full throughput.
// PARAMETERS
//  WIDTH     32  data width per channel
//  CHANNELS   8  number of input channels, >=2
//  SEL_W      3  select/channel-index width; must equal clog2(CHANNELS)
// PORTS
//  clk        in   1               clock, rising edge
//  rst        in   1               synchronous reset, active-high
//  mode       in   1               0 = fixed select, 1 = round-robin
//  sel        in   SEL_W           channel select, used when mode=0
//  in_data    in   CHANNELS*WIDTH  flattened inputs; channel i at [i*WIDTH +: WIDTH]
//  in_valid   in   CHANNELS        per-channel valid
//  in_ready   out  CHANNELS        per-channel ready; at most one bit high
//  out_data   out  WIDTH           registered selected data
//  out_chan   out  SEL_W           index of channel held in out_data
//  out_valid  out  1               output register holds data
//  out_ready  in   1               consumer accepts
//  out_par    out  1               even parity of out_data (MUXARB_PARITY_EN only)
// BEHAVIOUR
//  - Reset (rst=1 at posedge): out_valid=0, out_data=0, out_chan=0, out_par=0, rr_last=CHANNELS-1.
//    Reset mid-transfer discards the held word.
//  - State: EMPTY (out_valid=0) / FULL (out_valid=1).
//  - load = !out_valid | out_ready (combinational).
//  - grant (combinational, one-hot or zero):
//    - mode=0: grant channel sel if sel<CHANNELS, else no grant. Grant is independent of in_valid.
//    - mode=1: first channel with in_valid=1, searching rr_last+1, rr_last+2, ... wrapping modulo CHANNELS.
//      No grant if no channel is valid.
//  - in_ready[i] = load & grant[i]. Transfer on channel i when in_valid[i] & in_ready[i].
//  - On a transfer: next cycle out_data=in_data[i], out_chan=i, out_valid=1.
//    In mode=1, rr_last<=i. rr_last updates only on a transfer, never in mode=0.
//  - If load=1 and there is no transfer, out_valid<=0 (out_data and out_chan hold their last value).
//  - If out_valid=1 and out_ready=0: out_data, out_chan, out_valid are held stable and all in_ready=0.
//  - Simultaneous drain and refill (out_valid & out_ready & transfer): new word loaded, no bubble.
//    Sustained rate is 1 word per clk.
//  - Latency: input to out_valid is 1 cycle.
//  - mode or sel changes take effect in the same cycle. The word already in the register is unaffected.
//  - Round-robin fairness: a continuously valid channel is granted within CHANNELS transfers.
// CONFIGURATION
//  - MUXARB_PARITY_EN defined:
//    - out_par is a register loaded with ^in_data[i] alongside out_data (reset 0).
//    - out_par is held and cleared under the same rules as out_data.
//  - MUXARB_PARITY_EN undefined: out_par is tied to 1'b0 and no parity logic is generated.
// STRUCTURE
//  - Shared header mux_defs.vh:
//    - MODE_FIXED=1'b0, MODE_RR=1'b1.
//    - State encodings ST_EMPTY=1'b0, ST_FULL=1'b1.
//  - Sub-module rr_arbiter: parametrised by CHANNELS.
//    - Inputs: req[CHANNELS], last[SEL_W].
//    - Outputs: gnt[CHANNELS] one-hot, gnt_idx[SEL_W], any.
//    - Purely combinational; rr_last lives in mux_arb_reg.
//  - Top level holds the output register, rr_last, the mode mux and the handshake logic.
// TESTING (WIDTH=32, CHANNELS=8)
//  1. Reset: assert rst 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, in_ready=0 during reset.
//  2. Fixed mode: mode=0, sel=5, in_data ch5=32'hDEADBEEF valid, out_ready=1
//     -> in_ready=8'b0010_0000; next cycle out_data=DEADBEEF, out_chan=5.
//  3. Round-robin: mode=1, in_valid=8'hFF held, out_ready=1 -> out_chan sequence 0,1,...,7,0 on consecutive cycles.
//     Then in_valid=8'b1000_0100 -> grants alternate 2,7,2.
//  4. Backpressure: out_valid=1 with out_ready=0 for 3 cycles -> out_data/out_chan stable, in_ready=0.
//     Release -> drain and refill in the same cycle, no bubble.
//  5. Idle: in_valid=0, out_ready=1 -> out_valid falls the next cycle.
//     mode=0 with sel=5 and ch5 invalid -> no transfer; rr_last unchanged when switching back to mode=1.
//  6. Reset mid-stream: rst while out_valid=1 and out_ready=0 -> out_valid=0 next cycle.
//     After release, round-robin restarts at ch0.
//     With MUXARB_PARITY_EN: in_data=32'h0000_0007 -> out_par=1; with 32'h3 -> out_par=0.

Source files
------------

// File: rtl/mux_arb_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_arb_reg_pkg
// Description : Shared select-mode and output-register state encodings for
//               the mux_arb_reg selector.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_arb_reg_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage : mux_arb_reg_pkg
`default_nettype wire

// File: rtl/mux_arb_reg_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Searches from last+1
//               upward with wrap and grants the first requesting channel.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    last,
    output logic [CHANNELS-1:0] gnt,
    output logic [SEL_W-1:0]    gnt_idx,
    output logic                any
);

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        // Offsets 1..CHANNELS so the previous winner is considered last.
        for (int k = 1; k <= CHANNELS; k++) begin
            automatic int idx = (int'(last) + k) % CHANNELS;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = SEL_W'(idx);
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/mux_arb_reg.sv
`default_nettype none
// ============================================================================
// Module      : mux_arb_reg
// Description : N-to-1 selector with one registered output stage and a
//               valid/ready handshake; fixed-select or round-robin modes.
//               Optional parity output enabled by MUXARB_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_arb_reg
    import mux_arb_reg_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_par
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WIDTH-1:0]     r_data;
    logic [SEL_W-1:0]     r_chan;
    logic [SEL_W-1:0]     r_rr_last;

    logic                 w_load;
    logic                 w_accept;
    logic                 w_xfer;
    logic [CHANNELS-1:0]  w_fix_gnt;
    logic [CHANNELS-1:0]  w_rr_gnt;
    logic [SEL_W-1:0]     w_rr_idx;
    logic                 w_rr_any;
    logic [CHANNELS-1:0]  w_gnt;
    logic [SEL_W-1:0]     w_chan;
    logic [WIDTH-1:0]     w_data;

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_rr_arbiter (
        .req     (in_valid),
        .last    (r_rr_last),
        .gnt     (w_rr_gnt),
        .gnt_idx (w_rr_idx),
        .any     (w_rr_any)
    );

    // Out-of-range sel values match no channel, leaving the grant empty.
    always_comb begin
        w_fix_gnt = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_fix_gnt[i] = (int'(sel) == i);
        end
    end

    assign out_valid = (r_state == ST_FULL);
    assign w_load    = !out_valid || out_ready;
    assign w_accept  = w_load && !rst;
    assign w_gnt     = (mode == MODE_RR) ? w_rr_gnt : w_fix_gnt;
    assign w_chan    = (mode == MODE_RR) ? w_rr_idx : sel;
    assign in_ready  = w_accept ? w_gnt : '0;
    assign w_xfer    = (mode == MODE_RR) ? (w_accept && w_rr_any)
                                         : |(in_valid & in_ready);

    always_comb begin
        w_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_gnt[i]) begin
                w_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_load) begin
            w_state_nxt = w_xfer ? ST_FULL : ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data    <= '0;
            r_chan    <= '0;
            r_rr_last <= SEL_W'(CHANNELS - 1);
        end else if (w_xfer) begin
            r_data <= w_data;
            r_chan <= w_chan;
            if (mode == MODE_RR) begin
                r_rr_last <= w_rr_idx;
            end
        end
    end

    assign out_data = r_data;
    assign out_chan = r_chan;

`ifdef MUXARB_PARITY_EN
    logic r_par;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_par <= 1'b0;
        end else if (w_xfer) begin
            r_par <= ^w_data;
        end
    end

    assign out_par = r_par;
`else
    assign out_par = 1'b0;
`endif

endmodule : mux_arb_reg
`default_nettype wire
